multi_dataflow_out_packer: RTL
==============================

MULTI_DATAFLOW_OUT_PACKER -- requirements
Module: multi_dataflow_out_packer

Interface
REQ-001 Parameter PEL_WIDTH, default 8: pixel width taken from each input beat.
REQ-002 Parameter LANES, default 4: pixels packed per output word; the word is PEL_WIDTH*LANES bits (32 by default).
REQ-003 Parameter CNT_WIDTH, default 32: width of the length input and the counters.
REQ-004 One clock: clk_i  in  1  rising-edge clock.
REQ-005 Reset: rst_ni  in  1  asynchronous, active-low reset.
REQ-006 clear_i  in  1  synchronous soft clear.
REQ-007 start_i  in  1  starts a frame (single-cycle pulse).
REQ-008 cfg_len_i  in  CNT_WIDTH  number of pixels in the frame; sampled when start_i is accepted.
REQ-009 pel_valid_i / pel_ready_o  in / out  1 / 1  input stream handshake (the engine's out_pel stream).
REQ-010 pel_data_i  in  32  input beat; only bits [PEL_WIDTH-1:0] are used.
REQ-011 word_valid_o / word_ready_i  out / in  1 / 1  output stream handshake toward the TCDM sink streamer.
REQ-012 word_data_o  out  PEL_WIDTH*LANES  packed word.
REQ-013 word_strb_o  out  LANES  byte-lane strobe (per-pixel lane enable).
REQ-014 done_o  out  1  one-cycle pulse when the frame completes.
REQ-015 cnt_words_o  out  CNT_WIDTH  number of words handshaken in the current frame.
REQ-016 stall_cycles_o  out  CNT_WIDTH  count of output back-pressure cycles (see Configuration).

Function
REQ-017 The FSM SHALL have three states: IDLE, PACK and DRAIN.
- IDLE->PACK: start_i=1 and cfg_len_i!=0.
- IDLE, start_i=1 and cfg_len_i=0: done_o=1 on the next cycle; the FSM stays in IDLE.
REQ-018 start_i SHALL be ignored outside IDLE.
REQ-019 A remaining-pixel counter SHALL load cfg_len_i on start and decrement on each input handshake.
REQ-020 A lane index SHALL reset to 0 on start and increment modulo LANES on each input handshake.
REQ-021 The first pixel of a word SHALL go to lane 0, bits [PEL_WIDTH-1:0]; pixel k goes to lane k (little-endian).
REQ-022 pel_ready_o SHALL be 1 only in PACK when the output register is free: (!word_valid_o | word_ready_i).
REQ-023 An accepted pixel that fills lane LANES-1, or is the last pixel (remaining=1), SHALL commit the packed word to the output register at that clock edge.
- word_valid_o rises the next cycle, so latency is 1 cycle from the completing pixel.
REQ-024 Partial last word: word_strb_o SHALL have 1 only for the filled lanes, and unfilled data lanes SHALL be 0.
- Full word: strb='1.
REQ-025 word_valid_o/word_data_o/word_strb_o SHALL hold stable while word_valid_o=1 and word_ready_i=0.
REQ-026 On commit of the last word the FSM SHALL go PACK->DRAIN.
- In DRAIN, pel_ready_o=0.
- DRAIN->IDLE on the output handshake, with done_o=1 in that same cycle.
REQ-027 A simultaneous output handshake and new word commit SHALL replace the register contents with no bubble cycle.
REQ-028 cnt_words_o SHALL clear on an accepted start and increment on each output handshake.
- It holds its value after done until the next start.
REQ-029 Counters SHALL be CNT_WIDTH bits unsigned and saturate at all-ones.
REQ-030 Input beats arriving in IDLE or DRAIN SHALL be back-pressured and never dropped.

Reset
REQ-031 While rst_ni=0, the block SHALL be in IDLE and every output SHALL be 0, including pel_ready_o, word_valid_o and done_o; the accumulator and counters are 0.
REQ-032 clear_i=1 SHALL produce the same state as reset on the next edge.
- clear_i has priority over start_i and all handshakes.
- An in-flight word is discarded and no done_o is generated.
REQ-033 A reset or clear mid-frame SHALL leave no residual lane data in the next frame.

Configuration
REQ-034 Macro MULTI_DATAFLOW_PACKER_STATS_EN defined: stall_cycles_o SHALL count cycles with word_valid_o=1 and word_ready_i=0.
- It clears on start and clear, and saturates.
REQ-035 Macro MULTI_DATAFLOW_PACKER_STATS_EN undefined: stall_cycles_o SHALL be constant 0 and no counter logic is built.

Verification
REQ-036 Full words: cfg_len=8; pixels 0x01..0x08; word_ready=1 -> words 0x04030201 and 0x08070605 with strb 0xF, done_o pulse, cnt_words_o=2.
REQ-037 Partial word: cfg_len=5; pixels 0xA1..0xA5 -> words 0xA4A3A2A1 strb 0xF and then 0x000000A5 strb 0x1; done_o on the second handshake.
REQ-038 Back-pressure: cfg_len=8; word_ready=0 for 3 cycles after the first word -> pel_ready_o=0 while the register is full, and the word stays stable.
- With the macro defined: stall_cycles_o=3.
- Without the macro: stall_cycles_o=0.
REQ-039 Zero length: start with cfg_len=0 -> no word_valid_o, done_o=1 on the next cycle, FSM stays in IDLE.
REQ-040 Clear mid-frame: clear_i after 2 of 8 pixels, then a new start with cfg_len=4 and pixels 0x11..0x14 -> single word 0x14131211, strb 0xF, no stale lanes.
REQ-041 Async reset pulse mid-DRAIN -> all outputs 0 immediately, no done_o, and the next frame behaves normally.

Source files
------------

// File: rtl/multi_dataflow_out_packer.sv
// multi_dataflow_out_packer
// Packs a stream of PEL_WIDTH-bit pixels (one per input beat) into words of
// LANES pixels, little-endian (first pixel in lane 0). The last word of a
// frame may be partial; its strobe marks only the filled lanes and the
// unfilled data lanes are zero.
//
// Optional build feature: define MULTI_DATAFLOW_PACKER_STATS_EN to build the
// output back-pressure counter behind stall_cycles_o. Without the macro that
// port is tied to zero and no counter exists.
//
// A word commit and an output handshake may coincide in the same cycle, so
// the output register is refilled back-to-back without a bubble.
//
// clear_i behaves as a synchronous reset. While it is high, pel_ready_o is
// held low so that no pixel is lost to the abort, and done_o is suppressed.

module multi_dataflow_out_packer #(
    parameter int PEL_WIDTH = 8,
    parameter int LANES     = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         start_i,
    input  logic [CNT_WIDTH-1:0]         cfg_len_i,
    input  logic                         pel_valid_i,
    output logic                         pel_ready_o,
    input  logic [31:0]                  pel_data_i,
    output logic                         word_valid_o,
    input  logic                         word_ready_i,
    output logic [PEL_WIDTH*LANES-1:0]   word_data_o,
    output logic [LANES-1:0]             word_strb_o,
    output logic                         done_o,
    output logic [CNT_WIDTH-1:0]         cnt_words_o,
    output logic [CNT_WIDTH-1:0]         stall_cycles_o
);

    localparam int WORD_W = PEL_WIDTH * LANES;
    localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_stateNext;

    logic [CNT_WIDTH-1:0]   r_remain;
    logic [LIDX_W-1:0]      r_lane;
    logic [WORD_W-1:0]      r_accData;
    logic [LANES-1:0]       r_accStrb;

    logic                   r_wordValid;
    logic [WORD_W-1:0]      r_wordData;
    logic [LANES-1:0]       r_wordStrb;

    logic                   r_zeroDone;
    logic [CNT_WIDTH-1:0]   r_cntWords;

    logic                   w_startAcc;
    logic                   w_pelReady;
    logic                   w_inFire;
    logic                   w_outFire;
    logic                   w_lastPel;
    logic                   w_lastLane;
    logic                   w_commit;
    logic                   w_doneDrain;
    logic [WORD_W-1:0]      w_mergedData;
    logic [LANES-1:0]       w_mergedStrb;

    // Upper input bits beyond the pixel width are intentionally ignored.
    generate
        if (PEL_WIDTH < 32) begin : g_unusedBits
            logic w_unusedPelBits;
            assign w_unusedPelBits = ^pel_data_i[31:PEL_WIDTH];
        end
    endgenerate

    // start_i is only honoured in IDLE; elsewhere it is ignored.
    assign w_startAcc  = (r_state == IDLE) && start_i;

    // Input is accepted only while packing and the output register can take
    // a word this cycle (empty, or being drained by the sink right now).
    assign w_pelReady  = (r_state == PACK) && !clear_i &&
                         (!r_wordValid || word_ready_i);
    assign w_inFire    = pel_valid_i && w_pelReady;
    assign w_outFire   = r_wordValid && word_ready_i;

    assign w_lastPel   = (r_remain == CNT_WIDTH'(1));
    assign w_lastLane  = (r_lane == LIDX_W'(LANES - 1));
    assign w_commit    = w_inFire && (w_lastLane || w_lastPel);

    // The completion handshake of the final word reports done combinationally.
    assign w_doneDrain = (r_state == DRAIN) && w_outFire && !clear_i;

    // Merge the incoming pixel into its lane of the accumulator.
    always_comb begin
        w_mergedData = r_accData;
        w_mergedStrb = r_accStrb;
        for (int l = 0; l < LANES; l++) begin
            if (r_lane == LIDX_W'(l)) begin
                w_mergedData[l*PEL_WIDTH +: PEL_WIDTH] = pel_data_i[PEL_WIDTH-1:0];
                w_mergedStrb[l] = 1'b1;
            end
        end
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (start_i && (cfg_len_i != '0)) begin
                    w_stateNext = PACK;
                end
            end
            PACK: begin
                if (w_commit && w_lastPel) begin
                    w_stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (w_outFire) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State register; clear returns straight to IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else if (clear_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Remaining-pixel counter, loaded at start and decremented per pixel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_remain <= '0;
        end else if (clear_i) begin
            r_remain <= '0;
        end else if (w_startAcc) begin
            r_remain <= cfg_len_i;
        end else if (w_inFire && (r_remain != '0)) begin
            r_remain <= r_remain - CNT_WIDTH'(1);
        end
    end

    // Lane index and accumulator; emptied on every commit so no lane data
    // can leak from one word or frame into the next.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lane    <= '0;
            r_accData <= '0;
            r_accStrb <= '0;
        end else if (clear_i || w_startAcc) begin
            r_lane    <= '0;
            r_accData <= '0;
            r_accStrb <= '0;
        end else if (w_inFire) begin
            r_lane <= w_lastLane ? '0 : (r_lane + LIDX_W'(1));
            if (w_commit) begin
                r_accData <= '0;
                r_accStrb <= '0;
            end else begin
                r_accData <= w_mergedData;
                r_accStrb <= w_mergedStrb;
            end
        end
    end

    // Output word register; holds while stalled, refills on commit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wordValid <= 1'b0;
            r_wordData  <= '0;
            r_wordStrb  <= '0;
        end else if (clear_i) begin
            r_wordValid <= 1'b0;
            r_wordData  <= '0;
            r_wordStrb  <= '0;
        end else if (w_commit) begin
            r_wordValid <= 1'b1;
            r_wordData  <= w_mergedData;
            r_wordStrb  <= w_mergedStrb;
        end else if (w_outFire) begin
            r_wordValid <= 1'b0;
            r_wordData  <= '0;
            r_wordStrb  <= '0;
        end
    end

    // Zero-length frames complete one cycle after their start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_zeroDone <= 1'b0;
        end else begin
            r_zeroDone <= !clear_i && w_startAcc && (cfg_len_i == '0);
        end
    end

    // Words handshaken in the current frame, saturating.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cntWords <= '0;
        end else if (clear_i || w_startAcc) begin
            r_cntWords <= '0;
        end else if (w_outFire && (r_cntWords != '1)) begin
            r_cntWords <= r_cntWords + CNT_WIDTH'(1);
        end
    end

`ifdef MULTI_DATAFLOW_PACKER_STATS_EN
    logic [CNT_WIDTH-1:0] r_stallCycles;

    // Cycles where a word waits on the sink, saturating.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stallCycles <= '0;
        end else if (clear_i || w_startAcc) begin
            r_stallCycles <= '0;
        end else if (r_wordValid && !word_ready_i && (r_stallCycles != '1)) begin
            r_stallCycles <= r_stallCycles + CNT_WIDTH'(1);
        end
    end

    assign stall_cycles_o = r_stallCycles;
`else
    assign stall_cycles_o = '0;
`endif

    assign pel_ready_o  = w_pelReady;
    assign word_valid_o = r_wordValid;
    assign word_data_o  = r_wordData;
    assign word_strb_o  = r_wordStrb;
    assign done_o       = w_doneDrain || r_zeroDone;
    assign cnt_words_o  = r_cntWords;

endmodule
